serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single one-bit full-adder cell across an N-bit operand pair, one bit per clock, LSB first. It accepts a start request, loads and optionally conditions the operands, and steps the adder with a registered carry. It then publishes the sum, carry-out and signed overflow with a one-cycle done pulse. It trades throughput for area, so N-bit arithmetic costs one adder cell instead of N.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–32.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- sub  in  1  mode, sampled with start; 0 = a+b, 1 = a−b.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- ready  out  1  high only in IDLE.
- busy  out  1  high only in RUN.
- done  out  1  one-cycle pulse, high only in DONE.
- sum  out  WIDTH  last result; holds until the next DONE.
- c_out  out  1  final carry; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow of the last result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1.
  - Load a into A shift register.
  - Load b (or ~b when sub=1) into B shift register.
  - Set the carry register to sub.
  - Clear the bit counter to 0.
- RUN, each edge:
  - The full-adder cell takes A[0], B[0] and the carry register.
  - Its sum bit shifts into the MSB of the result shift register. A and B shift right.
  - The carry register takes the cell carry-out.
  - The counter increments.
  - On the edge processing bit WIDTH−1, the pre-update carry (carry into the MSB) is captured as c_msb.
- RUN → DONE on the edge where counter == WIDTH−1. On that same edge:
  - sum ← final result shift register contents.
  - c_out ← cell carry-out.
  - ovf ← c_msb XOR cell carry-out.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE: no queueing and no effect on the operands.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH. sum, c_out and ovf match the WIDTH-bit parallel add of a + (sub ? ~b : b) + sub.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, sum=0, c_out=0, ovf=0, and all internal registers 0.
- Reset is asynchronous. Asserting rst_n low mid-RUN aborts immediately: no done pulse, and outputs go to their reset values.
- Latency: with start accepted at edge k, busy is high for cycles k..k+WIDTH−1. done is high between edges k+WIDTH and k+WIDTH+1. ready returns after edge k+WIDTH+1.
- Minimum issue interval is WIDTH+2 edges.
- sum, c_out and ovf change only on the RUN→DONE edge or on reset. They are stable during RUN.
- ready, busy and done are decoded from the state register only, with no combinational path from inputs.
- Exactly one of ready, busy and done is high at any time.

## Structure
- Package serial_add_pkg:
  - State enum (IDLE, RUN, DONE).
  - Counter-width function clog2(WIDTH).
- Sub-module fa_cell: purely combinational one-bit full adder (a, b, cin → s, cout), built from two half-adder stages plus an OR. Instantiated exactly once.
- Top level holds the FSM, counter, three shift registers, carry register and output registers.

## Test plan
All scenarios use WIDTH=8.
- Add 0x3C + 0x45, sub=0 → after 9 edges, done pulse; sum=0x81, c_out=0, ovf=1.
- Add 0xFF + 0x01 → sum=0x00, c_out=1, ovf=0.
- Subtract 0x10 − 0x20 → sum=0xF0, c_out=0 (borrow), ovf=0.
- Subtract 0x80 − 0x01 → sum=0x7F, c_out=1, ovf=1.
- Hold start high with new operands throughout RUN and DONE:
  - The result is unchanged by the second set of operands.
  - A second operation is accepted on the first IDLE edge, so back-to-back ops are 10 edges apart.
- Assert rst_n low during bit 3 of an add:
  - ready=1 and sum/c_out/ovf=0 immediately, with no clock needed.
  - No done pulse occurs.
  - A subsequent add 0x01 + 0x01 yields sum=0x02.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_t : controller state encoding (IDLE, RUN, DONE)
//   clog2   : bit width needed to count 0..v-1 (minimum 1)
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    assign ha1_s = a ^ b;
    assign ha1_c = a & b;
    assign s     = ha1_s ^ cin;
    assign ha2_c = ha1_s & cin;
    assign cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Steps one full-adder cell across a
// WIDTH-bit operand pair, LSB first, one bit per clock.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, sub     : request and mode (0 = a+b, 1 = a-b), sampled when ready
//   a, b           : operands, sampled on the accepting edge
//   ready/busy/done: one-hot status decoded from the state register
//   sum, c_out, ovf: last result, final carry, two's-complement overflow
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands load on the accepting edge
// RUN   | one bit per edge through the adder cell, counter 0..WIDTH-1
// DONE  | one-cycle done pulse; result registers already updated
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_out_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic             c_msb;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // On the final bit the carry register still holds the carry into the MSB.
    assign c_msb    = carry_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert B and seed the carry.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    r_q     <= {fa_s, r_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= {fa_s, r_q[WIDTH-1:1]};
                        c_out_q <= fa_co;
                        ovf_q   <= c_msb ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int tests_run;
    int tests_failed;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 running, 2 done. Results come from a plain
    // (W+1)-bit addition of a + (sub ? ~b : b) + sub.
    int           m_phase;
    int           m_left;
    logic [W-1:0] m_sum;
    logic         m_c;
    logic         m_ovf;
    logic [W-1:0] p_sum;
    logic         p_c;
    logic         p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = '0;
            m_c     = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    logic [W-1:0] bb;
                    logic [W:0]   full;
                    bb    = sub ? ~b : b;
                    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
                    p_sum = full[W-1:0];
                    p_c   = full[W];
                    p_ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_sum   = p_sum;
                        m_c     = p_c;
                        m_ovf   = p_ovf;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", ready, m_phase == 0);
            check("busy",  busy,  m_phase == 1);
            check("done",  done,  m_phase == 2);
            check("sum",   sum,   m_sum);
            check("c_out", c_out, m_c);
            check("ovf",   ovf,   m_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", ready, 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vs, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        wait_ready();
        start = 1'b1; a = va; b = vb; sub = vs;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            a = $urandom; b = $urandom; sub = $urandom_range(1);
        end while (!done && n < 30);
        check({name, "_edges"}, n, 9);
        check({name, "_sum"}, sum, es);
        check({name, "_c"},   c_out, ec);
        check({name, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int n;
        int gap;
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_sum",   sum,   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add3c45", 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start held high across RUN/DONE with changing operands
        wait_ready();
        start = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'h70; b = 8'h20;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("hold_first_sum", sum, 8'h08);
        check("hold_first_c",   c_out, 0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 30);
        start = 1'b0;
        check("hold_gap", gap, 10);
        check("hold_second_sum", sum, 8'h90);
        check("hold_second_ovf", ovf, 1);

        // asynchronous reset during bit 3
        wait_ready();
        start = 1'b1; a = 8'h3C; b = 8'h45; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy",  busy,  0);
        check("arst_sum",   sum,   0);
        check("arst_c",     c_out, 0);
        check("arst_ovf",   ovf,   0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("arst_no_done", n, 0);
        run_op("add0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
